wb_sequencer: RTL and testbench
===============================

Name: wb_sequencer

Overview:
- Controls the register-file writeback path.
- Accepts one retiring instruction at a time and drives the 3-bit writeback-mux select, the write enable and the destination register.
- Sequences the multi-cycle and conditional writebacks: jmsub waits for memory data; bneal writes the link register only if the branch is taken.
- Sits between decode/execute and the 6-input writeback mux and the register file.

Parameters:
- LINK_REG, 31, register index written by jmsub/bneal/balrn
- TIMEOUT, 15, max cycles spent in MEM_WAIT before abort (1..2^TO_W-1)
- TO_W, 4, width of the timeout counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  retiring instruction present
- instr_ready  output  1  sequencer can accept (high only in IDLE)
- wb_class  input  3  0 normal, 1 sll, 2 ori, 3 jmsub, 4 bneal, 5 balrn, 6/7 illegal
- rd  input  5  destination register for classes 0/1/2
- branch_taken  input  1  bneal condition, sampled at accept
- mem_rdata_valid  input  1  memory read data valid (jmsub)
- wb_select  output  3  writeback mux select
- reg_write  output  1  register-file write enable, one-cycle pulse
- wb_addr  output  5  register-file write address
- busy  output  1  state != IDLE
- err_illegal  output  1  one-cycle pulse: class 6/7 accepted
- err_timeout  output  1  one-cycle pulse: MEM_WAIT aborted

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; timeout counter=0.
  - wb_select=0, wb_addr=0, reg_write=0, err_illegal=0, err_timeout=0, busy=0, instr_ready=1 once rst_n is released.
- Accept: instr_valid && instr_ready at a rising edge. wb_class, rd and branch_taken are captured at that edge. Inputs are ignored when not accepting.
- States: IDLE, MEM_WAIT, WRITE. All outputs are registered.
- IDLE, accept of:
  - class 0/1/2 -> WRITE; wb_select=class, wb_addr=rd.
  - class 5 -> WRITE; wb_select=5, wb_addr=LINK_REG.
  - class 4, branch_taken=1 -> WRITE; wb_select=4, wb_addr=LINK_REG.
  - class 4, branch_taken=0 -> stay IDLE; no write; outputs unchanged.
  - class 3 -> MEM_WAIT; wb_select=3, wb_addr=LINK_REG, counter cleared.
  - class 6/7 -> stay IDLE; err_illegal=1 for the following cycle; wb_select/wb_addr unchanged.
- WRITE (exactly one cycle):
  - reg_write=1, except reg_write=0 when wb_addr==0 (register $0 is never written).
  - Next state IDLE. Back-to-back accepts give at most one write every 2 cycles.
- MEM_WAIT:
  - mem_rdata_valid=1 -> WRITE.
  - Otherwise counter increments. When counter reaches TIMEOUT with no valid -> IDLE; err_timeout=1 for one cycle; no write.
  - mem_rdata_valid in the same cycle the counter reaches TIMEOUT: valid wins, go to WRITE.
  - mem_rdata_valid outside MEM_WAIT is ignored.
- Latency from the accept edge:
  - classes 0/1/2/5 and taken bneal: reg_write high in the cycle after accept.
  - jmsub: reg_write high in the cycle after mem_rdata_valid is sampled in MEM_WAIT.
- wb_select and wb_addr hold their last values in IDLE; the mux output is stable across idle periods.
- Reset asserted mid-operation: the pending instruction is dropped with no write, and all outputs go to reset values immediately.
- Error pulses never coincide with reg_write.

Test Plan:
- Reset, then accept class 2, rd=9 -> next cycle reg_write=1, wb_select=2, wb_addr=9; following cycle reg_write=0, instr_ready=1.
- Accept class 0 with rd=0 -> WRITE state with reg_write=0, wb_select=0; class 1 with rd=5 accepted 2 cycles later -> write to 5, select 1.
- Accept class 4 with branch_taken=1 -> write to addr 31, select 4. With branch_taken=0 -> no reg_write, busy stays 0, instr_ready stays 1.
- Accept class 3, assert mem_rdata_valid 4 cycles later -> instr_ready=0 throughout; reg_write=1 with addr 31, select 3 on the cycle after valid.
- Accept class 3 and never assert valid (TIMEOUT=15) -> err_timeout pulses once after 15 MEM_WAIT cycles, no reg_write, then IDLE. Repeat with valid on exactly the 15th cycle -> write occurs and no err_timeout.
- Accept class 7 -> err_illegal=1 for one cycle, select unchanged. Accept class 3 and pull rst_n low during MEM_WAIT -> all outputs 0 asynchronously; a later mem_rdata_valid produces no write.

Source files
------------

// File: rtl/wb_sequencer.sv
// Writeback sequencer: steers the 6-input writeback mux and register-file write port for one
// retiring instruction at a time, including jmsub memory wait and conditional bneal link write.
module wb_sequencer #(
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned TO_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_instr_valid,
    output logic       o_instr_ready,
    input  logic [2:0] i_wb_class,
    input  logic [4:0] i_rd,
    input  logic       i_branch_taken,
    input  logic       i_mem_rdata_valid,
    output logic [2:0] o_wb_select,
    output logic       o_reg_write,
    output logic [4:0] o_wb_addr,
    output logic       o_busy,
    output logic       o_err_illegal,
    output logic       o_err_timeout
);

    localparam logic [4:0]      LinkAddr   = 5'(LINK_REG);
    localparam logic [TO_W-1:0] TimeoutVal = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StMemWait,
        StWrite
    } state_t;

    state_t          r_state;
    logic [TO_W-1:0] r_cnt;
    logic [2:0]      r_wb_select;
    logic [4:0]      r_wb_addr;
    logic            r_reg_write;
    logic            r_busy;
    logic            r_ready;
    logic            r_err_illegal;
    logic            r_err_timeout;

    state_t          w_state_nxt;
    logic [TO_W-1:0] w_cnt_nxt;
    logic [TO_W-1:0] w_cnt_inc;
    logic [2:0]      w_sel_nxt;
    logic [4:0]      w_addr_nxt;
    logic            w_err_illegal_nxt;
    logic            w_err_timeout_nxt;
    logic            w_accept;

    assign w_accept  = i_instr_valid && r_ready;
    assign w_cnt_inc = r_cnt + TO_W'(1);

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_sel_nxt         = r_wb_select;
        w_addr_nxt        = r_wb_addr;
        w_err_illegal_nxt = 1'b0;
        w_err_timeout_nxt = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    case (i_wb_class)
                        3'd0, 3'd1, 3'd2: begin
                            w_state_nxt = StWrite;
                            w_sel_nxt   = i_wb_class;
                            w_addr_nxt  = i_rd;
                        end
                        3'd3: begin
                            w_state_nxt = StMemWait;
                            w_sel_nxt   = 3'd3;
                            w_addr_nxt  = LinkAddr;
                            w_cnt_nxt   = '0;
                        end
                        3'd4: begin
                            // Untaken bneal retires silently with the mux left untouched
                            if (i_branch_taken) begin
                                w_state_nxt = StWrite;
                                w_sel_nxt   = 3'd4;
                                w_addr_nxt  = LinkAddr;
                            end
                        end
                        3'd5: begin
                            w_state_nxt = StWrite;
                            w_sel_nxt   = 3'd5;
                            w_addr_nxt  = LinkAddr;
                        end
                        default: begin
                            w_err_illegal_nxt = 1'b1;
                        end
                    endcase
                end
            end
            StMemWait: begin
                // Data arriving on the final allowed cycle still wins over the abort
                if (i_mem_rdata_valid) begin
                    w_state_nxt = StWrite;
                end else if (w_cnt_inc == TimeoutVal) begin
                    w_state_nxt       = StIdle;
                    w_err_timeout_nxt = 1'b1;
                    w_cnt_nxt         = w_cnt_inc;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            StWrite: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_wb_select   <= 3'd0;
            r_wb_addr     <= 5'd0;
            r_reg_write   <= 1'b0;
            r_busy        <= 1'b0;
            r_ready       <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_wb_select   <= w_sel_nxt;
            r_wb_addr     <= w_addr_nxt;
            // Register $0 is hardwired, so its write strobe is suppressed
            r_reg_write   <= (w_state_nxt == StWrite) && (w_addr_nxt != 5'd0);
            r_busy        <= (w_state_nxt != StIdle);
            r_ready       <= (w_state_nxt == StIdle);
            r_err_illegal <= w_err_illegal_nxt;
            r_err_timeout <= w_err_timeout_nxt;
        end
    end

    assign o_instr_ready = r_ready;
    assign o_wb_select   = r_wb_select;
    assign o_reg_write   = r_reg_write;
    assign o_wb_addr     = r_wb_addr;
    assign o_busy        = r_busy;
    assign o_err_illegal = r_err_illegal;
    assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: a per-cycle vector table plus hand sequences for the
// MEM_WAIT timeout boundary and asynchronous reset during a pending jmsub.
module tb_wb_sequencer;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] wb_class;
    logic [4:0] rd;
    logic       branch_taken;
    logic       mem_rdata_valid;
    logic [2:0] wb_select;
    logic       reg_write;
    logic [4:0] wb_addr;
    logic       busy;
    logic       err_illegal;
    logic       err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    wb_sequencer #(
        .LINK_REG (31),
        .TIMEOUT  (15),
        .TO_W     (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_instr_valid     (instr_valid),
        .o_instr_ready     (instr_ready),
        .i_wb_class        (wb_class),
        .i_rd              (rd),
        .i_branch_taken    (branch_taken),
        .i_mem_rdata_valid (mem_rdata_valid),
        .o_wb_select       (wb_select),
        .o_reg_write       (reg_write),
        .o_wb_addr         (wb_addr),
        .o_busy            (busy),
        .o_err_illegal     (err_illegal),
        .o_err_timeout     (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] cls;
        logic [4:0] rd;
        logic       tk;
        logic       mv;
        logic       e_rdy;
        logic       e_busy;
        logic       e_rw;
        logic [2:0] e_sel;
        logic [4:0] e_addr;
        logic       e_ill;
        logic       e_to;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int v, input int cls, input int rdv, input int tk,
                                input int mv, input int rdy, input int bsy, input int rw,
                                input int sel, input int addr, input int ill, input int to);
        vec_t r;
        r.v      = 1'(v);
        r.cls    = 3'(cls);
        r.rd     = 5'(rdv);
        r.tk     = 1'(tk);
        r.mv     = 1'(mv);
        r.e_rdy  = 1'(rdy);
        r.e_busy = 1'(bsy);
        r.e_rw   = 1'(rw);
        r.e_sel  = 3'(sel);
        r.e_addr = 5'(addr);
        r.e_ill  = 1'(ill);
        r.e_to   = 1'(to);
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %0h, want %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic rdy, input logic bsy, input logic rw,
                             input logic [2:0] sel, input logic [4:0] addr, input logic ill,
                             input logic to);
        check("instr_ready", idx, 32'(instr_ready), 32'(rdy));
        check("busy", idx, 32'(busy), 32'(bsy));
        check("reg_write", idx, 32'(reg_write), 32'(rw));
        check("wb_select", idx, 32'(wb_select), 32'(sel));
        check("wb_addr", idx, 32'(wb_addr), 32'(addr));
        check("err_illegal", idx, 32'(err_illegal), 32'(ill));
        check("err_timeout", idx, 32'(err_timeout), 32'(to));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] cls, input logic [4:0] rdv,
                         input logic tk, input logic mv);
        instr_valid     = v;
        wb_class        = cls;
        rd              = rdv;
        branch_taken    = tk;
        mem_rdata_valid = mv;
    endtask

    initial begin
        //          v cls rd tk mv   rdy bsy rw sel addr ill to
        vecs.push_back(mk(1, 2,  9, 0, 0,  0, 1, 1, 2,  9, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0,  1, 0, 0, 2,  9, 0, 0));
        vecs.push_back(mk(1, 0,  0, 0, 0,  0, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 1,  5, 0, 0,  1, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 1,  5, 0, 0,  0, 1, 1, 1,  5, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 1,  1, 0, 0, 1,  5, 0, 0));
        vecs.push_back(mk(1, 4,  7, 1, 0,  0, 1, 1, 4, 31, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0,  1, 0, 0, 4, 31, 0, 0));
        vecs.push_back(mk(1, 4,  3, 0, 0,  1, 0, 0, 4, 31, 0, 0));
        vecs.push_back(mk(1, 5,  2, 0, 0,  0, 1, 1, 5, 31, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0,  1, 0, 0, 5, 31, 0, 0));
        vecs.push_back(mk(1, 7, 12, 0, 0,  1, 0, 0, 5, 31, 1, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0,  1, 0, 0, 5, 31, 0, 0));
        vecs.push_back(mk(1, 6, 12, 0, 0,  1, 0, 0, 5, 31, 1, 0));
        vecs.push_back(mk(1, 0,  3, 0, 0,  0, 1, 1, 0,  3, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0,  1, 0, 0, 0,  3, 0, 0));
        vecs.push_back(mk(1, 3,  4, 0, 0,  0, 1, 0, 3, 31, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0,  0, 1, 0, 3, 31, 0, 0));
        vecs.push_back(mk(1, 2,  9, 0, 0,  0, 1, 0, 3, 31, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0,  0, 1, 0, 3, 31, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 1,  0, 1, 1, 3, 31, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0,  1, 0, 0, 3, 31, 0, 0));

        rst_n = 1'b0;
        drive(1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        #12;
        check_all(1000, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_all(1001, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].cls, vecs[i].rd, vecs[i].tk, vecs[i].mv);
            step();
            check_all(i, vecs[i].e_rdy, vecs[i].e_busy, vecs[i].e_rw, vecs[i].e_sel,
                      vecs[i].e_addr, vecs[i].e_ill, vecs[i].e_to);
        end

        // jmsub with no data: abort on the 15th MEM_WAIT cycle
        drive(1'b1, 3'd3, 5'd1, 1'b0, 1'b0);
        step();
        drive(1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        check_all(2000, 1'b0, 1'b1, 1'b0, 3'd3, 5'd31, 1'b0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            step();
            check_all(2000 + k, 1'b0, 1'b1, 1'b0, 3'd3, 5'd31, 1'b0, 1'b0);
        end
        step();
        check_all(2015, 1'b1, 1'b0, 1'b0, 3'd3, 5'd31, 1'b0, 1'b1);
        step();
        check_all(2016, 1'b1, 1'b0, 1'b0, 3'd3, 5'd31, 1'b0, 1'b0);

        // jmsub with data on exactly the 15th MEM_WAIT cycle
        drive(1'b1, 3'd3, 5'd1, 1'b0, 1'b0);
        step();
        drive(1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            step();
            check_all(3000 + k, 1'b0, 1'b1, 1'b0, 3'd3, 5'd31, 1'b0, 1'b0);
        end
        mem_rdata_valid = 1'b1;
        step();
        mem_rdata_valid = 1'b0;
        check_all(3015, 1'b0, 1'b1, 1'b1, 3'd3, 5'd31, 1'b0, 1'b0);
        step();
        check_all(3016, 1'b1, 1'b0, 1'b0, 3'd3, 5'd31, 1'b0, 1'b0);

        // Reset while a jmsub is waiting for data
        drive(1'b1, 3'd3, 5'd1, 1'b0, 1'b0);
        step();
        drive(1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        step();
        check_all(4000, 1'b0, 1'b1, 1'b0, 3'd3, 5'd31, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all(4001, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        mem_rdata_valid = 1'b1;
        step();
        check_all(4002, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_all(4003, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        step();
        mem_rdata_valid = 1'b0;
        check_all(4004, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
